// File: rtl/cnn_pkg.sv
// Shared CNN datapath helpers: default sample width, saturation bounds,
// requantising shift/saturate and signed max.
package cnn_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam int SAT_MAX = (1 << (DEFAULT_DATA_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(1 << (DEFAULT_DATA_WIDTH - 1));

    function automatic logic signed [31:0] sat_max(input int dw);
        return (32'sd1 <<< (dw - 1)) - 32'sd1;
    endfunction

    function automatic logic signed [31:0] sat_min(input int dw);
        return -(32'sd1 <<< (dw - 1));
    endfunction

    // Arithmetic (flooring) right shift followed by clamp to a dw-bit signed range.
    function automatic logic signed [31:0] sat_shift(
        input logic signed [31:0] x,
        input int                 shift,
        input int                 dw
    );
        logic signed [31:0] q;
        q = x >>> shift;
        if (q > sat_max(dw)) begin
            q = sat_max(dw);
        end else if (q < sat_min(dw)) begin
            q = sat_min(dw);
        end
        return q;
    endfunction

    function automatic logic signed [31:0] smax(
        input logic signed [31:0] a,
        input logic signed [31:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/conv_pool2x2_requant_relu.sv
// Stage A: registered requantisation (shift, saturate, optional ReLU under
// CONV_POOL_RELU_EN) of the wide conv sum, with valid pass-through.
module requant_relu
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SHIFT      = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [2*DATA_WIDTH-1:0]      in_data,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_data
);

    logic signed [31:0]           sat_w;
    logic signed [DATA_WIDTH-1:0] q_next;

    always_comb begin
        sat_w = sat_shift(32'(signed'(in_data)), SHIFT, DATA_WIDTH);
`ifdef CONV_POOL_RELU_EN
        if (sat_w < 0) begin
            sat_w = '0;
        end
`endif
        q_next = sat_w[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= q_next;
            end
        end
    end

endmodule

// File: rtl/conv_pool2x2.sv
// Requantise conv partial sums and 2x2 stride-2 max-pool them in raster order.
// Optional ReLU in the requant stage is enabled by defining CONV_POOL_RELU_EN.
module conv_pool2x2
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IN_W       = 26,
    parameter int IN_H       = 26,
    parameter int SHIFT      = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    conv_valid,
    input  logic [2*DATA_WIDTH-1:0] conv_out,
    output logic [DATA_WIDTH-1:0]   pool_out,
    output logic                    pool_valid,
    output logic                    frame_done
);

    localparam int CW   = $clog2(IN_W + 1);
    localparam int RW   = $clog2(IN_H + 1);
    localparam int LB_N = IN_W / 2;
    localparam int LBW  = (LB_N > 1) ? $clog2(LB_N) : 1;

    logic                         a_valid;
    logic signed [DATA_WIDTH-1:0] a_data;

    requant_relu #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT      (SHIFT)
    ) u_requant (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (conv_valid),
        .in_data   (conv_out),
        .out_valid (a_valid),
        .out_data  (a_data)
    );

    logic [CW-1:0]                col;
    logic [RW-1:0]                row;
    logic signed [DATA_WIDTH-1:0] h_reg;
    logic [DATA_WIDTH-1:0]        lb [LB_N];

    logic                         col_last;
    logic                         row_last;
    logic                         h_wr;
    logic                         lb_wr;
    logic                         out_fire;
    logic [LBW-1:0]               lb_idx;
    logic signed [31:0]           m_w;
    logic signed [31:0]           win_w;
    logic signed [DATA_WIDTH-1:0] m_next;
    logic signed [DATA_WIDTH-1:0] win_next;

    always_comb begin
        col_last = (col == CW'(IN_W - 1));
        row_last = (row == RW'(IN_H - 1));
        // An even last column only exists for odd IN_W, and is dropped.
        h_wr     = a_valid && !col[0] && !col_last;
        // An even last row only exists for odd IN_H; it never pairs, so skip it.
        lb_wr    = a_valid && col[0] && !row[0] && !row_last;
        out_fire = a_valid && col[0] && row[0];
        lb_idx   = LBW'(col >> 1);
        m_w      = smax(32'(h_reg), 32'(a_data));
        m_next   = m_w[DATA_WIDTH-1:0];
        win_w    = smax(32'(signed'(lb[lb_idx])), 32'(m_next));
        win_next = win_w[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            h_reg      <= '0;
            pool_out   <= '0;
            pool_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pool_valid <= out_fire;
            pool_out   <= out_fire ? win_next : '0;
            frame_done <= a_valid && col_last && row_last;
            if (h_wr) begin
                h_reg <= a_data;
            end
            if (a_valid) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Line buffer holds no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (lb_wr) begin
            lb[lb_idx] <= m_next;
        end
    end

endmodule

// File: tb/tb_conv_pool2x2.sv
// Self-checking bench for conv_pool2x2: three instances (2x2, 4x4, 5x5 maps)
// driven with directed and random frames, checked against a window-level model.
module tb_conv_pool2x2;

    localparam int DW = 8;
    localparam int SH = 7;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       cv [3];
    logic [15:0] co [3];
    logic [7:0] po [3];
    logic       pv [3];
    logic       fd [3];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors   = 0;
    int checks   = 0;
    int idle_bad = 0;

    int ov  [3][$];
    int oc  [3][$];
    int fc  [3][$];
    int smp [3][$];
    int sc  [3][$];

    int dim_w [3] = '{2, 4, 5};
    int dim_h [3] = '{2, 4, 5};

    conv_pool2x2 #(.DATA_WIDTH(DW), .IN_W(2), .IN_H(2), .SHIFT(SH)) dut0 (
        .clk(clk), .rst_n(rst_n), .conv_valid(cv[0]), .conv_out(co[0]),
        .pool_out(po[0]), .pool_valid(pv[0]), .frame_done(fd[0]));
    conv_pool2x2 #(.DATA_WIDTH(DW), .IN_W(4), .IN_H(4), .SHIFT(SH)) dut1 (
        .clk(clk), .rst_n(rst_n), .conv_valid(cv[1]), .conv_out(co[1]),
        .pool_out(po[1]), .pool_valid(pv[1]), .frame_done(fd[1]));
    conv_pool2x2 #(.DATA_WIDTH(DW), .IN_W(5), .IN_H(5), .SHIFT(SH)) dut2 (
        .clk(clk), .rst_n(rst_n), .conv_valid(cv[2]), .conv_out(co[2]),
        .pool_out(po[2]), .pool_valid(pv[2]), .frame_done(fd[2]));

    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (pv[s] === 1'b1) begin
                ov[s].push_back(int'($signed(po[s])));
                oc[s].push_back(cyc);
            end else if (po[s] !== 8'd0) begin
                idle_bad++;
            end
            if (fd[s] === 1'b1) fc[s].push_back(cyc);
        end
    end

    // Reference: divide by 2^SHIFT rounding toward -inf, clamp, optional ReLU.
    function automatic int model_q(input int x);
        int q;
        q = x >>> SH;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
`ifdef CONV_POOL_RELU_EN
        if (q < 0) q = 0;
`endif
        return q;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int sel, input int val, input int gaps);
        @(negedge clk);
        cv[sel] = 1'b1;
        co[sel] = 16'(val);
        smp[sel].push_back(val);
        sc[sel].push_back(cyc);
        repeat (gaps) begin
            @(negedge clk);
            cv[sel] = 1'b0;
            co[sel] = 16'($urandom);
        end
    endtask

    task automatic idle(input int sel);
        @(negedge clk);
        cv[sel] = 1'b0;
        co[sel] = 16'($urandom);
    endtask

    task automatic ramp(input int sel, input int gaps);
        for (int r = 0; r < dim_h[sel]; r++)
            for (int c = 0; c < dim_w[sel]; c++)
                send(sel, (dim_w[sel] * r + c) * 128, gaps);
    endtask

    task automatic const_frame(input int sel, input int val);
        for (int n = 0; n < dim_w[sel] * dim_h[sel]; n++) send(sel, val, 0);
    endtask

    task automatic rand_frame(input int sel, input int maxgap);
        logic [15:0] r16;
        int          val;
        for (int n = 0; n < dim_w[sel] * dim_h[sel]; n++) begin
            r16 = 16'($urandom);
            if ($urandom_range(0, 1) == 1) val = int'($signed(r16));
            else val = int'($urandom_range(0, 40000)) - 20000;
            send(sel, val, int'($urandom_range(0, maxgap)));
        end
    endtask

    task automatic clear_q(input int sel);
        ov[sel].delete(); oc[sel].delete(); fc[sel].delete();
        smp[sel].delete(); sc[sel].delete();
    endtask

    task automatic check_frames(input int sel, input string tag);
        int w, h, nf, k, base, br, e;
        w = dim_w[sel];
        h = dim_h[sel];
        repeat (6) @(negedge clk);
        nf = smp[sel].size() / (w * h);
        k  = 0;
        check($sformatf("%s.count", tag), ov[sel].size(), nf * (w / 2) * (h / 2));
        for (int f = 0; f < nf; f++) begin
            base = f * w * h;
            for (int i = 0; i < h / 2; i++) begin
                for (int j = 0; j < w / 2; j++) begin
                    e = -1000;
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++)
                            if (model_q(smp[sel][base + (2*i+dr)*w + 2*j+dc]) > e)
                                e = model_q(smp[sel][base + (2*i+dr)*w + 2*j+dc]);
                    br = base + (2*i+1)*w + 2*j+1;
                    if (k < ov[sel].size()) begin
                        check($sformatf("%s.f%0d.w%0d_%0d.val", tag, f, i, j), ov[sel][k], e);
                        check($sformatf("%s.f%0d.w%0d_%0d.cyc", tag, f, i, j), oc[sel][k], sc[sel][br] + 2);
                    end
                    k++;
                end
            end
        end
        check($sformatf("%s.frame_done_count", tag), fc[sel].size(), nf);
        for (int f = 0; f < nf && f < fc[sel].size(); f++)
            check($sformatf("%s.f%0d.frame_done_cyc", tag, f), fc[sel][f], sc[sel][(f+1)*w*h - 1] + 2);
        $display("txn %s: frames=%0d outputs=%0d", tag, nf, ov[sel].size());
        clear_q(sel);
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            cv[s] = 1'b0;
            co[s] = '0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset.pool_out%0d", s), int'(po[s]), 0);
            check($sformatf("reset.pool_valid%0d", s), int'(pv[s]), 0);
            check($sformatf("reset.frame_done%0d", s), int'(fd[s]), 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        const_frame(0, 32767);  idle(0); check_frames(0, "sat_pos");
        const_frame(0, -32768); idle(0); check_frames(0, "sat_neg");

        ramp(1, 0);             idle(1); check_frames(1, "ramp4");
        ramp(1, 1);             idle(1); check_frames(1, "ramp4_gap");
        const_frame(1, -256);   idle(1); check_frames(1, "neg4");

        ramp(2, 0);             idle(2); check_frames(2, "ramp5");

        // Six ramp samples, then reset while the sixth is still in the pipe.
        for (int n = 0; n < 6; n++) send(1, ((n / 4) * 4 + (n % 4)) * 128, 0);
        @(negedge clk);
        cv[1] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_reset.outputs", ov[1].size(), 0);
        check("pre_reset.frame_done", fc[1].size(), 0);
        $display("txn reset_mid_frame: outputs_before=%0d", ov[1].size());
        clear_q(1);
        ramp(1, 0);             idle(1); check_frames(1, "post_reset");

        rand_frame(1, 0); rand_frame(1, 0); idle(1); check_frames(1, "b2b4");
        for (int t = 0; t < 4; t++) begin
            for (int s = 0; s < 3; s++) begin
                rand_frame(s, 2);
                rand_frame(s, 0);
                idle(s);
                check_frames(s, $sformatf("rand%0d_inst%0d", t, s));
            end
        end

        check("idle_pool_out_zero", idle_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_pool2x2.md
# conv_pool2x2

Downstream stage for the 3×3 multiply-accumulate convolution unit. It takes that unit's streaming signed partial sums (`conv_out`/`conv_valid`, raster order) and converts each one back to `DATA_WIDTH` by arithmetic shift, saturation and optional ReLU. It then applies 2×2 stride-2 max pooling over the feature map, using a half-width line buffer. There is no backpressure: the block accepts every valid sample on the cycle it arrives.

## Interface
- `DATA_WIDTH`, 8: output sample width; the input is `2*DATA_WIDTH` wide.
- `IN_W`, 26: feature-map columns per row (conv output width).
- `IN_H`, 26: feature-map rows per frame.
- `SHIFT`, 7: requantisation right-shift amount, 0 ≤ SHIFT < 2*DATA_WIDTH.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `conv_valid`  in  1  `conv_out` carries a sample this cycle.
- `conv_out`  in  2*DATA_WIDTH  signed two's-complement conv sum.
- `pool_out`  out  DATA_WIDTH  signed pooled sample; 0 whenever `pool_valid` = 0.
- `pool_valid`  out  1  one-cycle pulse per pooled sample.
- `frame_done`  out  1  one-cycle pulse after the last sample of a frame is processed.

## Operation
- **Stage A (requantise), registered.**
  - q = conv_out >>> SHIFT (arithmetic shift, floor).
  - Saturate q to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - Apply ReLU (see Configuration).
  - `a_valid` follows `conv_valid`.
- **Stage B (pool), registered.** Driven by `col` (0..IN_W−1) and `row` (0..IN_H−1).
  - Both counters advance only when `a_valid` = 1.
  - `col` wraps to 0 at IN_W−1 and increments `row`.
  - `row` wraps to 0 at IN_H−1.
- **Even `col`:** h_reg ← q.
- **Odd `col`:** m = max(h_reg, q), signed compare.
  - Even `row`: lb[col>>1] ← m.
  - Odd `row`: pool_out ← max(lb[col>>1], m); pool_valid ← 1.
- **Odd IN_W:** the final column (col = IN_W−1, even) is discarded and not written to h_reg.
- **Odd IN_H:** the final row is discarded; lb is not written and no output is produced.
- **Frame end:** frame_done ← 1 when the sample at (row = IN_H−1, col = IN_W−1) is processed in Stage B, regardless of parity.
- **Line buffer (`lb`):** IN_W/2 entries (floor) of DATA_WIDTH.
  - Contents are not reset.
  - Each entry is always written in the even row before it is read in the odd row of the same frame.
- **Input gaps:** `conv_valid` may be low for any number of cycles between samples. State holds and no output is produced.
- **Reset mid-frame:**
  - All counters, h_reg and pipeline valids clear.
  - The next valid sample is treated as (0,0).
  - No partial pooled output is ever emitted.

## Timing
- **Reset values:** pool_out = 0, pool_valid = 0, frame_done = 0, col = row = 0, Stage A registers 0.
- **Latency:** 2 cycles. A sample accepted at rising edge k (conv_valid = 1) reaches Stage A at edge k and Stage B at edge k+1. pool_valid / frame_done for the bottom-right sample of a window are high in the cycle after edge k+1.
- **Throughput:** one sample per cycle sustained. pool_valid is high for at most 1 of every 2 input samples and only during odd rows.
- **Pulse alignment:** for even IN_W and IN_H, frame_done rises in the same cycle as the frame's last pool_valid.
- **Back-to-back frames:** the first sample of frame n+1 may arrive the cycle after the last sample of frame n. No bubble is required.

## Configuration
- `CONV_POOL_RELU_EN` defined: after saturation, q < 0 becomes 0, so pool_out ≥ 0 always.
- `CONV_POOL_RELU_EN` undefined: negative q passes unchanged and pooling compares signed values.

## Structure
- **Shared package `cnn_pkg`:**
  - Default DATA_WIDTH.
  - Saturation bound constants SAT_MAX/SAT_MIN derived from DATA_WIDTH.
  - Function `sat_shift` (shift + saturate).
  - Function `smax` (signed max).
- **Sub-module `requant_relu`:** holds Stage A, i.e. the registered shift/saturate/ReLU with valid pass-through.
- **Top level:** contains counters, h_reg, lb and the output registers.

## Test plan
All scenarios use DATA_WIDTH = 8 and SHIFT = 7.
- **Saturation**
  - Stimulus: IN_W = IN_H = 2 with conv_out = 16'h7FFF ×4.
  - Response: pool_out = 127.
  - Stimulus: conv_out = 16'h8000 ×4, RELU off.
  - Response: pool_out = 8'h80 (−128). With RELU on: pool_out = 0.
- **Basic 4×4 ramp**
  - Stimulus: IN_W = IN_H = 4, conv_out = (4r+c)·128.
  - Response: pool_out 5, 7, 13, 15 in that order, each a single-cycle pulse 2 cycles after samples (1,1), (1,3), (3,1), (3,3).
  - frame_done is coincident with the 15.
- **Input gaps:** same ramp with conv_valid toggling every cycle. Response: identical outputs with identical latency relative to each accepted sample.
- **Negative values**
  - Stimulus: all samples = −256 (q = −2).
  - Response: RELU off gives pool_out = 8'hFE; RELU on gives 0.
- **Odd dimensions**
  - Stimulus: IN_W = IN_H = 5, ramp (5r+c)·128.
  - Response: exactly 4 outputs: 6, 8, 16, 18.
  - frame_done follows the 25th sample by 2 cycles.
- **Reset mid-frame**
  - Stimulus: 6 ramp samples into 4×4, assert rst_n low for 1 cycle, then a full 4×4 ramp.
  - Response: no output before reset; exactly 5, 7, 13, 15 afterwards.
